// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch stage and IF/ID pipeline register.
// Holds the PC, issues single-word requests to instruction memory and hands
// the fetched word to decode on instrD/pcplus4D/validD.
// Optional build macro: FETCH_TRACE_EN prints IF/ID loads and killed responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        kill_q, kill_d;
  logic [31:0] buf_instr_q, buf_pc4_q;
  logic        buf_load;
  logic        load_mem;
  logic        load_buf;
  logic [31:0] instr_q, pcplus4_q;
  logic        valid_q;

  // Wraps at 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  // State register: FSM state, PC, kill flag and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      if (buf_load) begin
        buf_instr_q <= imem_rdata;
        buf_pc4_q   <= pc_plus4;
      end
    end
  end

  // Next-state logic: request/response sequencing, skid capture and redirect.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    buf_load = 1'b0;
    load_mem = 1'b0;
    load_buf = 1'b0;
    unique case (state_q)
      StReq: begin
        state_d = StWait;
        // The request leaving this cycle targets the old PC.
        if (redirect) kill_d = 1'b1;
      end
      StWait: begin
        if (imem_valid) begin
          if (redirect || kill_q) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else if (!stall) begin
            load_mem = 1'b1;
            pc_d     = pc_plus4;
            state_d  = StReq;
          end else begin
            buf_load = 1'b1;
            state_d  = StHold;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StReq;
        end else if (!stall) begin
          load_buf = 1'b1;
          pc_d     = pc_plus4;
          state_d  = StReq;
        end
      end
      default: state_d = StReq;
    endcase
    // Redirect wins over any sequential PC update, stalled or not.
    if (redirect) pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  // Moore outputs: request pulse in REQ, suppressed while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (state_q == StReq && !rst) imem_req = 1'b1;
  end

  // IF/ID register: reset > flush > stall > load > bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_q   <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else if (stall) begin
      instr_q   <= instr_q;
      pcplus4_q <= pcplus4_q;
      valid_q   <= valid_q;
    end else if (load_mem) begin
      instr_q   <= imem_rdata;
      pcplus4_q <= pc_plus4;
      valid_q   <= 1'b1;
    end else if (load_buf) begin
      instr_q   <= buf_instr_q;
      pcplus4_q <= buf_pc4_q;
      valid_q   <= 1'b1;
    end else begin
      instr_q   <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end
  end

  assign instrD   = instr_q;
  assign pcplus4D = pcplus4_q;
  assign validD   = valid_q;

`ifdef FETCH_TRACE_EN
  logic discard;
  assign discard = (state_q == StWait) && imem_valid && (kill_q || redirect);

  // Trace of IF/ID loads and discarded responses.
  always_ff @(posedge clk) begin
    if (!rst && !flush && !stall && (load_mem || load_buf)) begin
      $display("%0t fetch: pc=%08h instr=%08h", $time, pc_q,
               load_mem ? imem_rdata : buf_instr_q);
    end
    if (!rst && discard) $display("fetch: killed");
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the MIPS core. Holds the PC, issues single-word requests to instruction memory, and presents the fetched word to the decode stage's `control` unit on `instrD`. Supports the following conditions:
- stall from the hazard unit;
- flush of the IF/ID register;
- PC redirect for taken branch, `j`, `jal` and `jr` targets computed downstream.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset (MIPS text base).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold PC, FSM progress and IF/ID register.
- `flush` in 1: replace IF/ID contents with a bubble.
- `redirect` in 1: load `redirect_pc` as the next fetch address.
- `redirect_pc` in 32: target; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 32: word address, equal to the PC while `imem_req` is high.
- `imem_valid` in 1: response strobe, arriving 1 or more cycles after `imem_req`.
- `imem_rdata` in 32: instruction word, qualified by `imem_valid`.
- `instrD` out 32: instruction to decode; 0 (`sll $0,$0,0`, a NOP) when invalid.
- `pcplus4D` out 32: PC+4 of `instrD`.
- `validD` out 1: `instrD` holds a real instruction.

## Operation
- Internal state: `pc`[31:0], FSM state, `kill` flag, and skid buffer `buf_instr`/`buf_pc4`.
- **REQ state:**
  - Drive `imem_req`=1 and `imem_addr`=`pc`.
  - Next state is WAIT unconditionally; `stall` does not block issue.
- **WAIT state:**
  - `imem_req`=0.
  - On `imem_valid` with `kill`=1: discard the word, clear `kill`, go to REQ.
  - On `imem_valid` with `kill`=0 and `stall`=0: load IF/ID with (`imem_rdata`, `pc`+4, valid=1), set `pc` to `pc`+4, go to REQ.
  - On `imem_valid` with `kill`=0 and `stall`=1: capture into the skid buffer, go to HOLD.
- **HOLD state:**
  - While `stall`=1, stay in HOLD.
  - When `stall`=0: load IF/ID from the buffer, set `pc` to `pc`+4, go to REQ.
- **Redirect** has the highest priority for the PC and is honoured even when `stall`=1:
  - `pc` is set to `{redirect_pc[31:2],2'b00}`.
  - In REQ: the request issued this cycle is stale; go to WAIT with `kill`=1.
  - In WAIT without `imem_valid`: set `kill`=1 and stay in WAIT.
  - In WAIT with `imem_valid`: discard the word and go to REQ.
  - In HOLD: drop the buffer and go to REQ.
  - A redirect never writes IF/ID; the downstream logic asserts `flush` alongside it.
- **IF/ID register priority:** `rst` > `flush` > `stall` > load > bubble.
  - `flush`: `validD`=0, `instrD`=0, `pcplus4D`=0.
  - `stall` without `flush`: hold all three outputs.
  - No word delivered and not stalled: insert a bubble (same values as `flush`).
- **Arithmetic:** PC+4 is a 32-bit add that wraps at 2^32 (32'hFFFF_FFFC + 4 = 0). The block raises no exception.
- **Ordering:** at most one request is outstanding. A further `imem_valid` while in REQ or HOLD is a protocol violation and is ignored.

## Timing
- **Reset** (any state, mid-transaction included), taking effect at the next edge:
  - `pc`=`RESET_PC`, state=REQ, `kill`=0, buffer cleared.
  - `instrD`=0, `pcplus4D`=0, `validD`=0.
  - `imem_req`=0 during the cycle `rst` is high. The first request is issued the cycle after `rst` falls.
  - Any response still in flight from before reset is dropped, because the block is in REQ.
- **Latency:** `imem_req` in cycle N with `imem_valid` in cycle N+k puts the word on `instrD` after the edge ending cycle N+k.
- **Throughput:** the next request is issued in cycle N+k+1, so peak throughput is one instruction per 2 cycles (k=1).
- **Outputs:** `imem_req` and `imem_addr` are Moore outputs (FSM/`pc`). `instrD`, `pcplus4D` and `validD` are registered.
- **Simultaneous `flush`+`stall`:** the bubble is inserted and the FSM still honours `stall` (a captured word waits in HOLD).
- **Simultaneous `redirect`+`imem_valid`+`stall`:** the word is discarded and the state is REQ next cycle.

## Configuration
- `FETCH_TRACE_EN`:
  - When defined, every IF/ID load prints `$time`, PC and `instrD` via `$display`, and every discarded (killed) response prints "fetch: killed".
  - When undefined, no display statements are compiled.
- Functional behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst` 2 cycles, release, k=1 memory → `imem_addr`=32'h0040_0000 in the first cycle after reset. `instrD` shows word 0 two cycles later with `pcplus4D`=32'h0040_0004, then 32'h0040_0004 is requested.
- **Stall in HOLD:** memory returns 32'h2008_0005 (`addi`) while `stall`=1 for 3 cycles → `instrD` holds its prior value, FSM sits in HOLD, no `imem_req`. The cycle after `stall` falls, `instrD`=32'h2008_0005 and a request for PC+4 issues.
- **Redirect during WAIT:** k=3 memory, redirect to 32'h0040_0100 in the cycle after the request → the late response is discarded (`validD` stays 0). The next `imem_addr` is 32'h0040_0100.
- **Misaligned redirect:** `redirect_pc`=32'h0040_0107 → next `imem_addr`=32'h0040_0104.
- **Flush and stall together:** `flush` and `stall` both high with `validD`=1 → next cycle `validD`=0, `instrD`=0.
- **PC wrap:** `redirect_pc`=32'hFFFF_FFFC, word delivered → `pcplus4D`=0 and the next `imem_addr`=0.
